// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Central hazard and stall controller for the five-stage pipeline with a data
// cache. It produces the stall/flush strobes for every inter-stage register,
// the E-stage operand forwarding selects, and runs a small state machine that
// freezes the pipeline for a fixed refill penalty on a data-cache miss.
//
// Parameters:
//   MISS_PENALTY : FILL cycles per data-cache miss (1..255)
//   CNT_W        : width of the miss-penalty counter
//
// Ports:
//   clk, rst                  : clock (rising edge), async active-high reset
//   Rs1D_i, Rs2D_i            : source registers of the instruction in D
//   Rs1E_i, Rs2E_i, RdE_i     : source/destination registers of the E instr
//   ResultSrcE0_i             : E-stage instruction is a load
//   PCSrcE_i                  : taken branch/jump resolved in E
//   RdM_i, RegWriteM_i        : M-stage destination and write enable
//   RdW_i, RegWriteW_i        : W-stage destination and write enable
//   MemAccessM_i              : M-stage instruction accesses memory
//   CacheMissM_i              : data cache miss for the M access
//   StallF_o, StallD_o        : hold PC / F-D register (StallD_o = active-low EN)
//   FlushD_o                  : clear F-D register (loads a nop)
//   StallE_o, FlushE_o        : hold / clear D-E register
//   StallM_o                  : hold E-M register
//   FlushW_o                  : bubble into M-W register
//   ForwardAE_o, ForwardBE_o  : 00 regfile, 10 from M, 01 from W
//   CacheFillReq_o            : registered line refill request
//   MissBusy_o                : state machine is in FILL
//
// Optional feature (macro HAZARD_PERF_EN):
//   Adds StallCycles_o[31:0] (cycles with StallF_o high) and
//   FlushCount_o[31:0] (cycles with FlushD_o high); both wrap and clear on rst.
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter int MISS_PENALTY = 4,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1D_i,
  input  logic [4:0] Rs2D_i,
  input  logic [4:0] Rs1E_i,
  input  logic [4:0] Rs2E_i,
  input  logic [4:0] RdE_i,
  input  logic       ResultSrcE0_i,
  input  logic       PCSrcE_i,
  input  logic [4:0] RdM_i,
  input  logic       RegWriteM_i,
  input  logic [4:0] RdW_i,
  input  logic       RegWriteW_i,
  input  logic       MemAccessM_i,
  input  logic       CacheMissM_i,
  output logic       StallF_o,
  output logic       StallD_o,
  output logic       FlushD_o,
  output logic       StallE_o,
  output logic       FlushE_o,
  output logic       StallM_o,
  output logic       FlushW_o,
  output logic [1:0] ForwardAE_o,
  output logic [1:0] ForwardBE_o,
  output logic       CacheFillReq_o,
  output logic       MissBusy_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] StallCycles_o,
  output logic [31:0] FlushCount_o
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FILL   = 2'b01,
    RESUME = 2'b10
  } miss_state_t;

  miss_state_t      state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             fill_req_r;

  logic             lw_stall_s;
  logic             miss_det_s;
  logic             miss_stall_s;
  logic [1:0]       fwd_a_s;
  logic [1:0]       fwd_b_s;

  // Forwarding selects: the younger result in M wins over the one in W; x0 never forwards.
  always_comb begin
    fwd_a_s = 2'b00;
    fwd_b_s = 2'b00;
    if (RegWriteM_i && (RdM_i != 5'd0) && (RdM_i == Rs1E_i)) begin
      fwd_a_s = 2'b10;
    end else if (RegWriteW_i && (RdW_i != 5'd0) && (RdW_i == Rs1E_i)) begin
      fwd_a_s = 2'b01;
    end else begin
      fwd_a_s = 2'b00;
    end
    if (RegWriteM_i && (RdM_i != 5'd0) && (RdM_i == Rs2E_i)) begin
      fwd_b_s = 2'b10;
    end else if (RegWriteW_i && (RdW_i != 5'd0) && (RdW_i == Rs2E_i)) begin
      fwd_b_s = 2'b01;
    end else begin
      fwd_b_s = 2'b00;
    end
  end

  // Hazard detection. A miss is only recognised in IDLE, so the RESUME cycle
  // masks a stale miss indication still presented by the cache.
  always_comb begin
    lw_stall_s   = ResultSrcE0_i && (RdE_i != 5'd0) &&
                   ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
    miss_det_s   = (state_r == IDLE) && MemAccessM_i && CacheMissM_i;
    miss_stall_s = miss_det_s || (state_r == FILL);
  end

  // Stall/flush strobes. A frozen pipeline is never flushed; a branch still
  // held in E flushes in the first cycle after the miss stall releases.
  always_comb begin
    StallF_o = lw_stall_s | miss_stall_s;
    StallD_o = lw_stall_s | miss_stall_s;
    StallE_o = miss_stall_s;
    StallM_o = miss_stall_s;
    FlushW_o = miss_stall_s;
    FlushD_o = PCSrcE_i & ~miss_stall_s;
    FlushE_o = (lw_stall_s | PCSrcE_i) & ~miss_stall_s;
  end

  assign ForwardAE_o    = fwd_a_s;
  assign ForwardBE_o    = fwd_b_s;
  assign CacheFillReq_o = fill_req_r;
  assign MissBusy_o     = (state_r == FILL);

  // Miss state machine: counter loads PENALTY-1 so FILL lasts exactly PENALTY cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      fill_req_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (miss_det_s) begin
            state_r    <= FILL;
            cnt_r      <= CNT_W'(MISS_PENALTY - 1);
            fill_req_r <= 1'b1;
          end else begin
            state_r    <= IDLE;
            fill_req_r <= 1'b0;
          end
        end
        FILL: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r    <= RESUME;
            fill_req_r <= 1'b0;
          end else begin
            cnt_r      <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        RESUME: begin
          state_r    <= IDLE;
          fill_req_r <= 1'b0;
        end
        default: begin
          state_r    <= IDLE;
          cnt_r      <= {CNT_W{1'b0}};
          fill_req_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_r;
  logic [31:0] flush_count_r;

  // Performance counters; free-running and wrap naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_r <= 32'd0;
      flush_count_r  <= 32'd0;
    end else begin
      if (StallF_o) begin
        stall_cycles_r <= stall_cycles_r + 32'd1;
      end
      if (FlushD_o) begin
        flush_count_r <= flush_count_r + 32'd1;
      end
    end
  end

  assign StallCycles_o = stall_cycles_r;
  assign FlushCount_o  = flush_count_r;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;
  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic       lde, pcsrc, wm, ww, mem, miss;
  logic       stall_f, stall_d, flush_d, stall_e, flush_e, stall_m, flush_w;
  logic [1:0] fwd_a, fwd_b;
  logic       fill_req, miss_busy;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  int total = 0;
  int bad   = 0;

  // reference model state: FILL cycles still to run, and a one-cycle resume mask
  int m_busy   = 0;
  bit m_resume = 1'b0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MISS_PENALTY(P), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .Rs1D_i(rs1d), .Rs2D_i(rs2d), .Rs1E_i(rs1e), .Rs2E_i(rs2e), .RdE_i(rde),
    .ResultSrcE0_i(lde), .PCSrcE_i(pcsrc),
    .RdM_i(rdm), .RegWriteM_i(wm), .RdW_i(rdw), .RegWriteW_i(ww),
    .MemAccessM_i(mem), .CacheMissM_i(miss),
    .StallF_o(stall_f), .StallD_o(stall_d), .FlushD_o(flush_d),
    .StallE_o(stall_e), .FlushE_o(flush_e), .StallM_o(stall_m), .FlushW_o(flush_w),
    .ForwardAE_o(fwd_a), .ForwardBE_o(fwd_b),
    .CacheFillReq_o(fill_req), .MissBusy_o(miss_busy)
`ifdef HAZARD_PERF_EN
    , .StallCycles_o(stall_cycles), .FlushCount_o(flush_count)
`endif
  );

  task automatic clear_inputs();
    rs1d = 5'd0; rs2d = 5'd0; rs1e = 5'd0; rs2e = 5'd0; rde = 5'd0;
    rdm = 5'd0; rdw = 5'd0; lde = 1'b0; pcsrc = 1'b0; wm = 1'b0; ww = 1'b0;
    mem = 1'b0; miss = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    #2;
    total++;
    if ({stall_f, stall_d, flush_d, stall_e, flush_e, stall_m, flush_w, fill_req, miss_busy} !== 9'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=000000000",
               {stall_f, stall_d, flush_d, stall_e, flush_e, stall_m, flush_w, fill_req, miss_busy});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if ({stall_f, fill_req, miss_busy} !== 3'b000) begin
      bad++;
      $display("FAIL post_reset_idle got=%b want=000", {stall_f, fill_req, miss_busy});
    end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    clear_inputs();
    lde = 1'b1; rde = 5'd5; rs1d = 5'd5;
    #1;
    total++;
    if ({stall_f, stall_d, flush_e, flush_d, stall_e} !== 5'b11100) begin
      bad++;
      $display("FAIL load_use got=%b want=11100", {stall_f, stall_d, flush_e, flush_d, stall_e});
    end
    // the stall inserted a bubble into E, so the hazard is gone next cycle
    @(negedge clk);
    lde = 1'b0; rde = 5'd0;
    #1;
    total++;
    if ({stall_f, stall_d, flush_e} !== 3'b000) begin
      bad++;
      $display("FAIL load_use_release got=%b want=000", {stall_f, stall_d, flush_e});
    end
    // load into x0 never stalls
    lde = 1'b1; rde = 5'd0; rs1d = 5'd0;
    #1;
    total++;
    if (stall_f !== 1'b0) begin
      bad++;
      $display("FAIL load_use_x0 got=%b want=0", stall_f);
    end
    clear_inputs();
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    clear_inputs();
    wm = 1'b1; rdm = 5'd3; ww = 1'b1; rdw = 5'd3; rs1e = 5'd3; rs2e = 5'd0;
    #1;
    total++;
    if ({fwd_a, fwd_b} !== 4'b1000) begin
      bad++;
      $display("FAIL fwd_m_priority got=%b want=1000", {fwd_a, fwd_b});
    end
    rdm = 5'd0;
    #1;
    total++;
    if (fwd_a !== 2'b01) begin
      bad++;
      $display("FAIL fwd_w got=%b want=01", fwd_a);
    end
    rdm = 5'd7; rs2e = 5'd7; wm = 1'b0;
    #1;
    total++;
    if ({fwd_a, fwd_b} !== 4'b0100) begin
      bad++;
      $display("FAIL fwd_m_nowrite got=%b want=0100", {fwd_a, fwd_b});
    end
    clear_inputs();
  endtask

  task automatic test_branch();
    @(negedge clk);
    clear_inputs();
    pcsrc = 1'b1;
    #1;
    total++;
    if ({flush_d, flush_e, stall_f} !== 3'b110) begin
      bad++;
      $display("FAIL branch_flush got=%b want=110", {flush_d, flush_e, stall_f});
    end
    @(negedge clk);
    pcsrc = 1'b0;
    #1;
    total++;
    if ({flush_d, flush_e} !== 2'b00) begin
      bad++;
      $display("FAIL branch_release got=%b want=00", {flush_d, flush_e});
    end
  endtask

  task automatic test_miss();
    @(negedge clk);
    clear_inputs();
    mem = 1'b1; miss = 1'b1;
    for (int c = 0; c <= P; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      total++;
      if ({stall_f, stall_e, stall_m, flush_w, fill_req, miss_busy} !== {4'b1111, (c > 0), (c > 0)}) begin
        bad++;
        $display("FAIL miss_cycle%0d got=%b want=1111%b%b", c,
                 {stall_f, stall_e, stall_m, flush_w, fill_req, miss_busy}, (c > 0), (c > 0));
      end
    end
    @(negedge clk);
    #1;
    total++;
    if ({stall_f, stall_e, fill_req, miss_busy} !== 4'b0000) begin
      bad++;
      $display("FAIL miss_resume got=%b want=0000", {stall_f, stall_e, fill_req, miss_busy});
    end
    @(negedge clk);
    #1;
    total++;
    if ({stall_f, fill_req} !== 2'b10) begin
      bad++;
      $display("FAIL miss_back_to_back got=%b want=10", {stall_f, fill_req});
    end
    @(negedge clk);
    clear_inputs();
    repeat (P + 2) @(negedge clk);
    #1;
    total++;
    if ({stall_f, miss_busy, fill_req} !== 3'b000) begin
      bad++;
      $display("FAIL miss_drain got=%b want=000", {stall_f, miss_busy, fill_req});
    end
  endtask

  task automatic test_miss_branch();
    @(negedge clk);
    clear_inputs();
    mem = 1'b1; miss = 1'b1;
    #1;
    total++;
    if ({stall_f, flush_d} !== 2'b10) begin
      bad++;
      $display("FAIL missbr_detect got=%b want=10", {stall_f, flush_d});
    end
    @(negedge clk);
    mem = 1'b0; miss = 1'b0; pcsrc = 1'b1;
    for (int c = 1; c <= P; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      total++;
      if ({stall_f, flush_d, flush_e, miss_busy} !== 4'b1001) begin
        bad++;
        $display("FAIL missbr_frozen%0d got=%b want=1001", c, {stall_f, flush_d, flush_e, miss_busy});
      end
    end
    @(negedge clk);
    #1;
    total++;
    if ({stall_f, flush_d, flush_e} !== 3'b011) begin
      bad++;
      $display("FAIL missbr_release got=%b want=011", {stall_f, flush_d, flush_e});
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    clear_inputs();
    mem = 1'b1; miss = 1'b1;
    @(negedge clk);
    mem = 1'b0; miss = 1'b0;
    @(negedge clk);  // counter now 2
    #1;
    total++;
    if ({miss_busy, fill_req} !== 2'b11) begin
      bad++;
      $display("FAIL areset_pre got=%b want=11", {miss_busy, fill_req});
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({miss_busy, fill_req, stall_f} !== 3'b000) begin
      bad++;
      $display("FAIL areset_immediate got=%b want=000", {miss_busy, fill_req, stall_f});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if ({miss_busy, fill_req, stall_f} !== 3'b000) begin
      bad++;
      $display("FAIL areset_idle got=%b want=000", {miss_busy, fill_req, stall_f});
    end
  endtask

  task automatic test_random();
    logic lw, md, ms;
    logic [1:0] ea, eb;
    logic [10:0] exp_v, got_v;
    m_busy = 0; m_resume = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rs1d = 5'($urandom_range(0, 3)); rs2d = 5'($urandom_range(0, 3));
      rs1e = 5'($urandom_range(0, 3)); rs2e = 5'($urandom_range(0, 3));
      rde  = 5'($urandom_range(0, 3)); rdm  = 5'($urandom_range(0, 3));
      rdw  = 5'($urandom_range(0, 3));
      lde = 1'($urandom_range(0, 1)); wm = 1'($urandom_range(0, 1));
      ww  = 1'($urandom_range(0, 1)); mem = 1'($urandom_range(0, 1));
      miss = ($urandom_range(0, 2) == 0); pcsrc = ($urandom_range(0, 3) == 0);
      #1;
      lw = lde && (rde != 5'd0) && (rde == rs1d || rde == rs2d);
      md = (m_busy == 0) && !m_resume && mem && miss;
      ms = md || (m_busy > 0);
      ea = (wm && rdm != 5'd0 && rdm == rs1e) ? 2'b10 :
           (ww && rdw != 5'd0 && rdw == rs1e) ? 2'b01 : 2'b00;
      eb = (wm && rdm != 5'd0 && rdm == rs2e) ? 2'b10 :
           (ww && rdw != 5'd0 && rdw == rs2e) ? 2'b01 : 2'b00;
      exp_v = {lw || ms, pcsrc && !ms, ms, (lw || pcsrc) && !ms, ea, eb,
               (m_busy > 0), (m_busy > 0), stall_d == stall_f};
      got_v = {stall_f, flush_d, stall_e, flush_e, fwd_a, fwd_b,
               fill_req, miss_busy, (stall_m == stall_e) && (flush_w == stall_e)};
      exp_v[0] = 1'b1;
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL random_cycle%0d got=%b want=%b", i, got_v, exp_v);
      end
      @(posedge clk);
      if (m_resume) m_resume = 1'b0;
      else if (md) m_busy = P;
      else if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) m_resume = 1'b1;
      end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_forwarding();
    test_branch();
    test_miss();
    test_miss_branch();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
